te_frame_sched: RTL

//  Schedules MIPI DSI command-mode frame writes against the panel TE (tearing-effect) signal.

---
 rtl/mipi_cmd_pkg.sv | 22 ++
 rtl/te_sync_edge.sv | 38 +++
 rtl/te_frame_sched.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mipi_cmd_pkg.sv
// Shared DCS opcodes and scheduler state encoding for the TE-driven frame scheduler.
`default_nettype none

package mipi_cmd_pkg;

  localparam logic [7:0] DCS_WR_MEM_START = 8'h2C;
  localparam logic [7:0] DCS_WR_MEM_CONT  = 8'h3C;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_TE = 2'd1,
    CMD     = 2'd2,
    XFER    = 2'd3
  } sched_state_t;

  function automatic logic [7:0] dcs_for_line(input logic i_first_line);
    return i_first_line ? DCS_WR_MEM_START : DCS_WR_MEM_CONT;
  endfunction

endpackage

`default_nettype wire

// File: rtl/te_sync_edge.sv
// te_sync_edge: synchronises the asynchronous panel TE and emits a one-cycle rising-edge pulse.
// The pulse lands SYNC_STAGES+1 cycles after te_in is first sampled high.
`default_nettype none

module te_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_te,
  output logic o_te_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_lvl;
  logic                   r_lvl_d;
  logic                   r_rise;

  // Edge detect runs on a retimed copy of the synchronised level, registered at the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_lvl   <= 1'b0;
      r_lvl_d <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_te};
      r_lvl   <= r_sync[SYNC_STAGES-1];
      r_lvl_d <= r_lvl;
      r_rise  <= r_lvl & ~r_lvl_d;
    end
  end

  assign o_te_rise = r_rise;

endmodule

`default_nettype wire

// File: rtl/te_frame_sched.sv
// te_frame_sched: issues one DCS write command per line after a TE edge, with tear and TE-loss tracking.
// Build option TE_FREERUN_EN: a watchdog timeout with a frame ready starts the frame without TE.
`default_nettype none

module te_frame_sched
  import mipi_cmd_pkg::*;
#(
  parameter int LINES       = 1080,
  parameter int SYNC_STAGES = 2,
  parameter int TE_TIMEOUT  = 4500000,
  parameter int CNT_W       = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        te_in,
  input  logic        frame_ready,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_dcs,
  output logic [10:0] line_idx,
  input  logic        line_done,
  output logic        busy,
  output logic        frame_done,
  output logic        te_timeout,
  output logic [7:0]  tear_cnt
);

  sched_state_t     r_state;
  sched_state_t     w_state_nxt;
  logic [10:0]      r_line;
  logic [CNT_W-1:0] r_wd;
  logic             r_timeout;
  logic [7:0]       r_tear;
  logic             r_frame_done;
  logic             w_te_rise;
  logic             w_last;
  logic             w_wd_expire;
  logic             w_start;
  logic             w_busy;

  te_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_te_sync (
    .clk       (clk),
    .rst       (rst),
    .i_te      (te_in),
    .o_te_rise (w_te_rise)
  );

  assign w_last      = (r_line == 11'(LINES - 1));
  assign w_busy      = (r_state == CMD) || (r_state == XFER);
  // A TE edge in the same cycle as expiry wins: it restarts the watchdog instead of flagging.
  assign w_wd_expire = (r_state == WAIT_TE) && !w_te_rise && (r_wd == CNT_W'(TE_TIMEOUT - 1));
  assign w_start     = (r_state == WAIT_TE) && (w_state_nxt == CMD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (enable) w_state_nxt = WAIT_TE;
      end
      WAIT_TE: begin
        if (!enable) begin
          w_state_nxt = IDLE;
        end else if (w_te_rise && frame_ready) begin
          w_state_nxt = CMD;
        end
`ifdef TE_FREERUN_EN
        else if (w_wd_expire && frame_ready) begin
          w_state_nxt = CMD;
        end
`endif
      end
      CMD: begin
        if (cmd_ready) w_state_nxt = XFER;
      end
      XFER: begin
        if (line_done) w_state_nxt = w_last ? WAIT_TE : CMD;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_line       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= (r_state == XFER) && line_done && w_last;
      if (w_start) begin
        r_line <= '0;
      end else if ((r_state == XFER) && line_done && !w_last) begin
        r_line <= r_line + 11'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
      r_tear    <= '0;
    end else begin
      if ((r_state != WAIT_TE) || (w_state_nxt != WAIT_TE) || w_te_rise || w_wd_expire) begin
        r_wd <= '0;
      end else begin
        r_wd <= r_wd + 1'b1;
      end
      if (w_te_rise) begin
        r_timeout <= 1'b0;
      end else if (w_wd_expire) begin
        r_timeout <= 1'b1;
      end
      if (w_te_rise && w_busy && (r_tear != 8'hFF)) begin
        r_tear <= r_tear + 8'd1;
      end
    end
  end

  assign cmd_valid  = (r_state == CMD);
  assign cmd_dcs    = dcs_for_line(r_line == 11'd0);
  assign line_idx   = r_line;
  assign busy       = w_busy;
  assign frame_done = r_frame_done;
  assign te_timeout = r_timeout;
  assign tear_cnt   = r_tear;

endmodule

`default_nettype wire
